// File: rtl/sl_tx_serializer.sv
// Read-domain consumer of the SL async FIFO: pops words and sends each one as an
// idle-high serial frame (start, data LSB-first, optional odd parity, stop bits).
module sl_tx_serializer #(
    parameter int DATA_SIZE = 8,
    parameter int BIT_DIV   = 16,
    parameter int PARITY_EN = 1,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_SIZE-1:0] fifo_rd_data,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_inc,
    input  logic                 tx_en,
    output logic                 tx_line,
    output logic                 tx_busy,
    output logic                 frame_done
);

    localparam int DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam int BIT_W = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BIT_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_PRE   = DIV_W'(BIT_DIV - 2);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_SIZE - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t               state_r;
    logic [DIV_W-1:0]     div_cnt_r;
    logic [BIT_W-1:0]     bit_cnt_r;
    logic [DATA_SIZE-1:0] shift_reg_r;
    logic [DATA_SIZE-1:0] shift_nxt_s;
    logic                 par_r;
    logic                 tx_line_r;
    logic                 tx_busy_r;
    logic                 frame_done_r;
    logic [1:0]           guard_cnt_r;
    logic                 guard_ok_s;
    logic                 div_last_s;
    logic                 stop_last_s;
    logic                 done_next_s;
    logic                 pop_ok_s;

    function automatic logic odd_parity(input logic [DATA_SIZE-1:0] word);
        return ~(^word);
    endfunction

    assign fifo_rd_inc = pop_ok_s;
    assign tx_line     = tx_line_r;
    assign tx_busy     = tx_busy_r;
    assign frame_done  = frame_done_r;

    // Bit-boundary decode and the pop decision (only in IDLE or on the final stop clk).
    always_comb begin
        guard_ok_s  = (guard_cnt_r == 2'd2);
        div_last_s  = (div_cnt_r == DIV_LAST);
        shift_nxt_s = {1'b0, shift_reg_r[DATA_SIZE-1:1]};
        if (state_r == ST_STOP && bit_cnt_r == STOP_LAST) begin
            stop_last_s = div_last_s;
            done_next_s = (div_cnt_r == DIV_PRE);
        end else begin
            stop_last_s = 1'b0;
            done_next_s = 1'b0;
        end
        if (state_r == ST_IDLE || stop_last_s) begin
            pop_ok_s = tx_en & ~fifo_empty & guard_ok_s;
        end else begin
            pop_ok_s = 1'b0;
        end
    end

    // Startup guard: holds off popping for two clocks after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            guard_cnt_r <= 2'd0;
        end else if (!guard_ok_s) begin
            guard_cnt_r <= guard_cnt_r + 2'd1;
        end else begin
            guard_cnt_r <= guard_cnt_r;
        end
    end

    // Frame FSM; the line value for the next bit is registered at each bit boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            div_cnt_r    <= '0;
            bit_cnt_r    <= '0;
            shift_reg_r  <= '0;
            par_r        <= 1'b0;
            tx_line_r    <= 1'b1;
            tx_busy_r    <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= done_next_s;
            case (state_r)
                ST_IDLE: begin
                    div_cnt_r <= '0;
                    bit_cnt_r <= '0;
                    if (pop_ok_s) begin
                        state_r     <= ST_START;
                        shift_reg_r <= fifo_rd_data;
                        par_r       <= odd_parity(fifo_rd_data);
                        tx_line_r   <= 1'b0;
                        tx_busy_r   <= 1'b1;
                    end else begin
                        tx_line_r <= 1'b1;
                        tx_busy_r <= 1'b0;
                    end
                end
                ST_START: begin
                    if (div_last_s) begin
                        state_r   <= ST_DATA;
                        div_cnt_r <= '0;
                        bit_cnt_r <= '0;
                        tx_line_r <= shift_reg_r[0];
                    end else begin
                        div_cnt_r <= div_cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_DATA: begin
                    if (!div_last_s) begin
                        div_cnt_r <= div_cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
                    end else if (bit_cnt_r != DATA_LAST) begin
                        div_cnt_r   <= '0;
                        bit_cnt_r   <= bit_cnt_r + {{(BIT_W-1){1'b0}}, 1'b1};
                        shift_reg_r <= shift_nxt_s;
                        tx_line_r   <= shift_nxt_s[0];
                    end else if (PARITY_EN != 0) begin
                        state_r   <= ST_PARITY;
                        div_cnt_r <= '0;
                        tx_line_r <= par_r;
                    end else begin
                        state_r   <= ST_STOP;
                        div_cnt_r <= '0;
                        bit_cnt_r <= '0;
                        tx_line_r <= 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (div_last_s) begin
                        state_r   <= ST_STOP;
                        div_cnt_r <= '0;
                        bit_cnt_r <= '0;
                        tx_line_r <= 1'b1;
                    end else begin
                        div_cnt_r <= div_cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_STOP: begin
                    if (!div_last_s) begin
                        div_cnt_r <= div_cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
                    end else if (!stop_last_s) begin
                        div_cnt_r <= '0;
                        bit_cnt_r <= bit_cnt_r + {{(BIT_W-1){1'b0}}, 1'b1};
                        tx_line_r <= 1'b1;
                    end else if (pop_ok_s) begin
                        state_r     <= ST_START;
                        div_cnt_r   <= '0;
                        bit_cnt_r   <= '0;
                        shift_reg_r <= fifo_rd_data;
                        par_r       <= odd_parity(fifo_rd_data);
                        tx_line_r   <= 1'b0;
                        tx_busy_r   <= 1'b1;
                    end else begin
                        state_r   <= ST_IDLE;
                        div_cnt_r <= '0;
                        bit_cnt_r <= '0;
                        tx_line_r <= 1'b1;
                        tx_busy_r <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    div_cnt_r <= '0;
                    bit_cnt_r <= '0;
                    tx_line_r <= 1'b1;
                    tx_busy_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sl_tx_serializer.sv
// Bench for sl_tx_serializer: a FIFO model feeds randomized words; every pop queues
// the frame's expected per-clock line waveform, which a monitor process compares.
`timescale 1ns/1ps
module tb_sl_tx_serializer;

    localparam int DW = 8;
    localparam int BD = 16;
    localparam int PE = 1;
    localparam int SB = 1;

    typedef struct packed {
        logic line;
        logic done;
    } slot_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_en = 1'b1;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_rd_data = 8'h00;
    logic       fifo_rd_inc, tx_line, tx_busy, frame_done;
    logic       inc2, line2, busy2, done2;
    logic       inc3, line3, busy3, done3;

    logic [7:0] fq[$];
    slot_t      exp_q[$];
    bit         pop_now = 1'b0;
    bit         end_req = 1'b0;
    int         stim_timeouts = 0;
    int         guard_edges = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    sl_tx_serializer #(.DATA_SIZE(DW), .BIT_DIV(BD), .PARITY_EN(PE), .STOP_BITS(SB)) u_dut (
        .clk(clk), .rst_n(rst_n), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
        .fifo_rd_inc(fifo_rd_inc), .tx_en(tx_en), .tx_line(tx_line), .tx_busy(tx_busy),
        .frame_done(frame_done)
    );

    sl_tx_serializer #(.DATA_SIZE(8), .BIT_DIV(2), .PARITY_EN(0), .STOP_BITS(1)) u_sw2 (
        .clk(clk), .rst_n(rst_n), .fifo_rd_data(8'h3C), .fifo_empty(1'b0),
        .fifo_rd_inc(inc2), .tx_en(1'b1), .tx_line(line2), .tx_busy(busy2),
        .frame_done(done2)
    );

    sl_tx_serializer #(.DATA_SIZE(8), .BIT_DIV(2), .PARITY_EN(0), .STOP_BITS(2)) u_sw3 (
        .clk(clk), .rst_n(rst_n), .fifo_rd_data(8'hC3), .fifo_empty(1'b0),
        .fifo_rd_inc(inc3), .tx_en(1'b1), .tx_line(line3), .tx_busy(busy3),
        .frame_done(done3)
    );

    // Rising edges seen since reset release (saturates once popping is allowed).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) guard_edges <= 0;
        else if (guard_edges < 3) guard_edges <= guard_edges + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish, compared=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus (sole owner of the FIFO model) ----------------
    task automatic fifo_refresh();
        fifo_empty   = (fq.size() == 0);
        fifo_rd_data = fifo_empty ? 8'h00 : fq[0];
    endtask

    task automatic tick();
        @(negedge clk);
        pop_now = fifo_rd_inc;
        @(posedge clk);
        #1;
        if (pop_now && fq.size() != 0) void'(fq.pop_front());
        fifo_refresh();
    endtask

    task automatic wait_pop(input int limit);
        pop_now = 1'b0;
        for (int i = 0; i < limit && !pop_now; i++) tick();
        if (!pop_now) stim_timeouts++;
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) fq.push_back(8'($urandom_range(0, 255)));
        fifo_refresh();
    endtask

    initial begin : stimulus
        // reset held with data present and tx_en high; 0xA5 goes out after release
        fq.push_back(8'hA5);
        fifo_refresh();
        repeat (5) tick();
        rst_n = 1'b1;
        repeat (200) tick();
        // back-to-back 0x00, 0xFF
        fq.push_back(8'h00);
        fq.push_back(8'hFF);
        fifo_refresh();
        repeat (400) tick();
        // enabled but empty
        repeat (500) tick();
        // tx_en drops in the middle of data bit 3
        push_words(4);
        wait_pop(10);
        repeat (72) tick();
        tx_en = 1'b0;
        repeat (300) tick();
        // reset pulse in the middle of data bit 5
        tx_en = 1'b1;
        wait_pop(10);
        repeat (104) tick();
        #2;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (600) tick();
        // randomized traffic and enable toggling
        for (int it = 0; it < 20; it++) begin
            push_words(int'($urandom_range(0, 3)));
            tx_en = ($urandom_range(0, 3) != 0);
            repeat (int'($urandom_range(20, 400))) tick();
        end
        tx_en = 1'b1;
        for (int i = 0; i < 3000 && fq.size() != 0; i++) tick();
        repeat (200) tick();
        end_req = 1'b1;
    end

    // ---------------- monitor / scoreboard ----------------
    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    task automatic push_frame(input logic [7:0] w);
        bit    bits[$];
        slot_t s;
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits.push_back(w[i]);
        if (PE != 0) bits.push_back(~(^w));
        for (int i = 0; i < SB; i++) bits.push_back(1'b1);
        for (int j = 0; j < bits.size(); j++) begin
            for (int k = 0; k < BD; k++) begin
                s.line = bits[j];
                s.done = (j == bits.size() - 1) && (k == BD - 1);
                exp_q.push_back(s);
            end
        end
    endtask

    initial begin : monitor
        slot_t cur;
        bit    have, pop_exp;
        int    sw_cnt2 = 0, sw_cnt3 = 0, sw_frames2 = 0, sw_frames3 = 0, frames_main = 0;
        bit    sw_seen2 = 1'b0, sw_seen3 = 1'b0;
        while (!end_req) begin
            @(negedge clk or negedge rst_n);
            #1;
            if (!rst_n) begin
                exp_q.delete();
                sw_seen2 = 1'b0;
                sw_seen3 = 1'b0;
                check("rst_tx_line", tx_line, 1);
                check("rst_rd_inc", fifo_rd_inc, 0);
                check("rst_busy", tx_busy, 0);
                check("rst_frame_done", frame_done, 0);
            end else begin
                have = (exp_q.size() != 0);
                if (have) begin
                    cur = exp_q.pop_front();
                end else begin
                    cur.line = 1'b1;
                    cur.done = 1'b0;
                end
                pop_exp = tx_en && !fifo_empty && (guard_edges >= 2) && (!have || cur.done);
                check("tx_line", tx_line, cur.line);
                check("frame_done", frame_done, cur.done);
                check("tx_busy", tx_busy, have);
                check("fifo_rd_inc", fifo_rd_inc, pop_exp);
                if (pop_exp) begin
                    push_frame(fifo_rd_data);
                    frames_main++;
                end
                sw_cnt2++;
                sw_cnt3++;
                if (done2) begin
                    if (sw_seen2) check("sweep_len_p0_s1", sw_cnt2, 20);
                    check("sweep_stop_line_s1", line2, 1);
                    check("sweep_busy_s1", busy2, 1);
                    check("sweep_b2b_pop_s1", inc2, 1);
                    sw_seen2 = 1'b1;
                    sw_cnt2 = 0;
                    sw_frames2++;
                end
                if (done3) begin
                    if (sw_seen3) check("sweep_len_p0_s2", sw_cnt3, 22);
                    check("sweep_stop_line_s2", line3, 1);
                    check("sweep_busy_s2", busy3, 1);
                    check("sweep_b2b_pop_s2", inc3, 1);
                    sw_seen3 = 1'b1;
                    sw_cnt3 = 0;
                    sw_frames3++;
                end
            end
        end
        check("stim_wait_bounds", stim_timeouts, 0);
        check("sweep_frames_seen", int'(sw_frames2 > 5 && sw_frames3 > 5), 1);
        check("fifo_drained", fq.size(), 0);
        check("main_frames_sent", int'(frames_main >= 8), 1);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
